// File: rtl/pl_irq_event_coalescer_if.sv
// Signal bundle for pl_irq_event_coalescer: raw events, acks and configuration in;
// coalesced level interrupts, batch counts and overflow flags out.
interface pl_irq_event_coalescer_if #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
);
  logic [NUM_SRC-1:0]       evt_in;
  logic [CNT_W-1:0]         thresh;
  logic [TMO_W-1:0]         timeout;
  logic [NUM_SRC-1:0]       ack;
  logic [NUM_SRC-1:0]       intr_out;
  logic [NUM_SRC*CNT_W-1:0] batch_cnt;
  logic [NUM_SRC-1:0]       ovf;

  // master: event sources plus the interrupt peripheral; slave: the coalescer
  modport master (
    output evt_in, thresh, timeout, ack,
    input  intr_out, batch_cnt, ovf
  );

  modport slave (
    input  evt_in, thresh, timeout, ack,
    output intr_out, batch_cnt, ovf
  );
endinterface

// File: rtl/pl_irq_event_coalescer.sv
// Per-source event coalescer: sync + edge detect, then IDLE/COLLECT/FIRE with carry and overflow.
// Timeout firing is built only when PL_IRQ_COAL_TIMEOUT_EN is defined; otherwise threshold only.
module pl_irq_event_coalescer #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TMO_W       = 16
) (
  input  logic ACLK,
  input  logic ARESET,
  pl_irq_event_coalescer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef PL_IRQ_COAL_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
`endif

  logic [CNT_W-1:0]         eff_thresh;
  logic [NUM_SRC-1:0]       intr_vec;
  logic [NUM_SRC-1:0]       ovf_vec;
  logic [NUM_SRC*CNT_W-1:0] batch_vec;

  assign eff_thresh    = (bus.thresh == '0) ? CNT_ONE : bus.thresh;
  assign bus.intr_out  = intr_vec;
  assign bus.ovf       = ovf_vec;
  assign bus.batch_cnt = batch_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // SYNC_STAGES must be at least 2; the chain shifts toward the MSB
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   s_dly_q, s_dly_d;
      state_t                 state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic [CNT_W-1:0]       carry_q, carry_d;
      logic [CNT_W-1:0]       batch_q, batch_d;
      logic                   intr_q, intr_d;
      logic                   ovf_q, ovf_d;
      logic                   evt;
      logic                   ack_i;
      logic                   tmo_hit;
      logic [CNT_W-1:0]       cnt_inc;
      logic [CNT_W-1:0]       carry_inc;

      assign evt       = sync_q[SYNC_STAGES-1] & ~s_dly_q;
      assign ack_i     = bus.ack[gi];
      assign cnt_inc   = (evt && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
      assign carry_inc = (evt && (carry_q != CNT_MAX)) ? carry_q + CNT_ONE : carry_q;

`ifdef PL_IRQ_COAL_TIMEOUT_EN
      logic [TMO_W-1:0] tmo_q, tmo_d;
      logic [TMO_W:0]   tmo_plus1;

      // one extra bit so a saturated tmo can never alias onto a small timeout
      assign tmo_plus1 = {1'b0, tmo_q} + (TMO_W+1)'(1);
      assign tmo_hit   = (bus.timeout != '0) && (tmo_plus1 == {1'b0, bus.timeout});
`else
      assign tmo_hit   = 1'b0;
`endif

      always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], bus.evt_in[gi]};
        s_dly_d = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        batch_d = batch_q;
        ovf_d   = ovf_q;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        // registered one cycle behind FIRE so every re-fire shows a low cycle
        intr_d  = (state_q == ST_FIRE) && !ack_i;

        unique case (state_q)
          ST_IDLE: begin
            if (evt) begin
              cnt_d = CNT_ONE;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
              tmo_d = '0;
`endif
              if (eff_thresh <= CNT_ONE) begin
                state_d = ST_FIRE;
                batch_d = CNT_ONE;
              end else begin
                state_d = ST_COLLECT;
              end
            end
          end

          ST_COLLECT: begin
            cnt_d = cnt_inc;
            if ((cnt_inc >= eff_thresh) || tmo_hit) begin
              state_d = ST_FIRE;
              batch_d = cnt_inc;
              carry_d = '0;
            end else begin
`ifdef PL_IRQ_COAL_TIMEOUT_EN
              tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_ONE;
`endif
            end
          end

          ST_FIRE: begin
            // the event lands in carry before the ack decides where to go
            carry_d = carry_inc;
            if (evt && (carry_q == CNT_MAX)) begin
              ovf_d = 1'b1;
            end
            if (ack_i) begin
              ovf_d   = 1'b0;
              carry_d = '0;
              if (carry_inc == '0) begin
                state_d = ST_IDLE;
              end else begin
                cnt_d = carry_inc;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (carry_inc >= eff_thresh) begin
                  state_d = ST_FIRE;
                  batch_d = carry_inc;
                end else begin
                  state_d = ST_COLLECT;
                end
              end
            end
          end

          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          sync_q  <= '0;
          s_dly_q <= 1'b0;
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          carry_q <= '0;
          batch_q <= '0;
          intr_q  <= 1'b0;
          ovf_q   <= 1'b0;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end else begin
          sync_q  <= sync_d;
          s_dly_q <= s_dly_d;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          carry_q <= carry_d;
          batch_q <= batch_d;
          intr_q  <= intr_d;
          ovf_q   <= ovf_d;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
          tmo_q   <= tmo_d;
`endif
        end
      end

      assign intr_vec[gi]                  = intr_q;
      assign ovf_vec[gi]                   = ovf_q;
      assign batch_vec[gi*CNT_W +: CNT_W]  = batch_q;
    end
  endgenerate

endmodule

// File: tb/tb_pl_irq_event_coalescer.sv
// Bench for pl_irq_event_coalescer: directed scenarios plus random traffic, all checked every
// cycle against an event-level model; honours PL_IRQ_COAL_TIMEOUT_EN like the design.
module tb_pl_irq_event_coalescer;
  localparam int NS    = 4;
  localparam int SY    = 2;
  localparam int CW    = 4;
  localparam int TW    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int TMAXV = (1 << TW) - 1;

  logic clk = 1'b0;
  logic srst;
  int   errors = 0;
  int   checks = 0;

  pl_irq_event_coalescer_if #(.NUM_SRC(NS), .CNT_W(CW), .TMO_W(TW)) bus_if ();

  pl_irq_event_coalescer #(
    .NUM_SRC(NS), .SYNC_STAGES(SY), .CNT_W(CW), .TMO_W(TW)
  ) dut (
    .ACLK  (clk),
    .ARESET(srst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // model: input samples per source, collected events (0 = none), cycles since batch start,
  // events held back while signalling, reported batch, signalling flag, outputs
  int hist [NS][SY+2];
  int col  [NS];
  int age  [NS];
  int car  [NS];
  int bat  [NS];
  bit sig  [NS];
  bit m_intr [NS];
  bit m_ovf  [NS];

  function automatic void begin_batch(int i, int k, int et);
    if (k >= et) begin
      sig[i] = 1'b1;
      bat[i] = k;
      col[i] = 0;
    end else begin
      col[i] = k;
      age[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int et;
    int e;
    int n;
    bit fo;
    et = (bus_if.thresh == '0) ? 1 : int'(bus_if.thresh);
    for (int i = 0; i < NS; i++) begin
      if (srst) begin
        for (int k = 0; k < SY + 2; k++) hist[i][k] = 0;
        col[i] = 0; age[i] = 0; car[i] = 0; bat[i] = 0;
        sig[i] = 1'b0; m_intr[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        for (int k = SY + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = int'(bus_if.evt_in[i]);
        e = (hist[i][SY] == 1 && hist[i][SY+1] == 0) ? 1 : 0;
        m_intr[i] = sig[i] && !bus_if.ack[i];
        if (sig[i]) begin
          if (e == 1) begin
            if (car[i] == CMAX) m_ovf[i] = 1'b1;
            else car[i] = car[i] + 1;
          end
          if (bus_if.ack[i]) begin
            m_ovf[i] = 1'b0;
            sig[i]   = 1'b0;
            n        = car[i];
            car[i]   = 0;
            if (n > 0) begin_batch(i, n, et);
          end
        end else if (col[i] > 0) begin
          n = (col[i] + e > CMAX) ? CMAX : col[i] + e;
`ifdef PL_IRQ_COAL_TIMEOUT_EN
          fo = (bus_if.timeout != '0) && (age[i] + 1 == int'(bus_if.timeout));
`else
          fo = 1'b0;
`endif
          if (n >= et || fo) begin
            sig[i] = 1'b1;
            bat[i] = n;
            col[i] = 0;
          end else begin
            col[i] = n;
            age[i] = (age[i] == TMAXV) ? age[i] : age[i] + 1;
          end
        end else if (e == 1) begin
          begin_batch(i, 1, et);
        end
      end
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dut=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: advance the model on the edge, compare everything on the falling edge
  task automatic tick();
    logic [NS-1:0] ei;
    logic [NS-1:0] eo;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      ei[i] = m_intr[i];
      eo[i] = m_ovf[i];
    end
    check("cyc_intr_out", 32'(bus_if.intr_out), 32'(ei));
    check("cyc_ovf", 32'(bus_if.ovf), 32'(eo));
    for (int i = 0; i < NS; i++) begin
      if (m_intr[i]) check("cyc_batch_cnt", 32'(bus_if.batch_cnt[i*CW +: CW]), 32'(bat[i]));
    end
    $display("cycle t=%0t evt=%b ack=%b thr=%0d intr=%b ovf=%b batch=%h",
             $time, bus_if.evt_in, bus_if.ack, bus_if.thresh, bus_if.intr_out, bus_if.ovf,
             bus_if.batch_cnt);
  endtask

  task automatic pulse(int i);
    bus_if.evt_in[i] = 1'b1;
    tick(); tick();
    bus_if.evt_in[i] = 1'b0;
    tick(); tick();
  endtask

  task automatic ack_pulse(int i);
    bus_if.ack[i] = 1'b1;
    tick();
    bus_if.ack[i] = 1'b0;
  endtask

  task automatic wait_intr(int i, int budget);
    int n;
    n = 0;
    while (!bus_if.intr_out[i] && n < budget) begin
      tick();
      n++;
    end
    check("wait_intr", 32'(bus_if.intr_out[i]), 32'd1);
  endtask

  int hold [NS];

  initial begin
    srst           = 1'b1;
    bus_if.evt_in  = '0;
    bus_if.ack     = '0;
    bus_if.thresh  = CW'(4);
    bus_if.timeout = '0;

    // reset held with toggling inputs; quiet inputs for the last cycles before release
    for (int c = 0; c < 10; c++) begin
      bus_if.evt_in = (c < 8 && ((c / 2) % 2) == 0) ? 4'hF : 4'h0;
      tick();
      check("rst_intr_out", 32'(bus_if.intr_out), 32'd0);
      check("rst_batch_cnt", 32'(bus_if.batch_cnt), 32'd0);
      check("rst_ovf", 32'(bus_if.ovf), 32'd0);
    end
    srst = 1'b0;
    repeat (3) tick();

    // threshold 4 on src0, fire latency measured from the 4th rising edge
    bus_if.thresh = CW'(4);
    repeat (3) pulse(0);
    bus_if.evt_in[0] = 1'b1;
    for (int t = 1; t <= SY + 2; t++) begin
      tick();
      if (t == 2) bus_if.evt_in[0] = 1'b0;
      if (t == SY + 1) check("thr_before_fire", 32'(bus_if.intr_out[0]), 32'd0);
    end
    check("thr_fire", 32'(bus_if.intr_out[0]), 32'd1);
    check("thr_batch", 32'(bus_if.batch_cnt[0 +: CW]), 32'd4);
    ack_pulse(0);
    check("thr_ack_low", 32'(bus_if.intr_out[0]), 32'd0);
    tick();
    check("thr_idle_low", 32'(bus_if.intr_out[0]), 32'd0);

    // partial batch of 3 on src1 with thresh 8, timeout 100
    bus_if.thresh  = CW'(8);
    bus_if.timeout = TW'(100);
    for (int t = 0; t < SY + 102; t++) begin
      bus_if.evt_in[1] = (t < 12) && ((t % 4) < 2);
      tick();
      if (t == SY + 100) check("tmo_before_fire", 32'(bus_if.intr_out[1]), 32'd0);
    end
`ifdef PL_IRQ_COAL_TIMEOUT_EN
    check("tmo_fire", 32'(bus_if.intr_out[1]), 32'd1);
    check("tmo_batch", 32'(bus_if.batch_cnt[CW +: CW]), 32'd3);
    ack_pulse(1);
    tick();
`else
    check("no_tmo_fire", 32'(bus_if.intr_out[1]), 32'd0);
    repeat (50) tick();
    check("no_tmo_still_low", 32'(bus_if.intr_out[1]), 32'd0);
    repeat (5) pulse(1);
    wait_intr(1, 20);
    check("no_tmo_batch", 32'(bus_if.batch_cnt[CW +: CW]), 32'd8);
    ack_pulse(1);
    tick();
`endif
    bus_if.timeout = '0;

    // carry of 5 on src2 re-fires with one low cycle
    bus_if.thresh = CW'(2);
    pulse(2); pulse(2);
    wait_intr(2, 20);
    repeat (5) pulse(2);
    tick(); tick();
    ack_pulse(2);
    check("refire_low", 32'(bus_if.intr_out[2]), 32'd0);
    tick();
    check("refire_high", 32'(bus_if.intr_out[2]), 32'd1);
    check("refire_batch", 32'(bus_if.batch_cnt[2*CW +: CW]), 32'd5);
    ack_pulse(2);
    tick(); tick();

    // 20 events while src3 signals: carry saturates at 15 and ovf sticks until ack
    pulse(3); pulse(3);
    wait_intr(3, 20);
    repeat (20) pulse(3);
    tick(); tick();
    check("ovf_set", 32'(bus_if.ovf[3]), 32'd1);
    ack_pulse(3);
    check("ovf_clear", 32'(bus_if.ovf[3]), 32'd0);
    check("ovf_refire_low", 32'(bus_if.intr_out[3]), 32'd0);
    tick();
    check("ovf_refire_high", 32'(bus_if.intr_out[3]), 32'd1);
    check("ovf_carry_batch", 32'(bus_if.batch_cnt[3*CW +: CW]), 32'd15);
    ack_pulse(3);
    tick(); tick();

    // event and ack in the same cycle on src0: carry 1, collect resumes at 1
    pulse(0); pulse(0);
    wait_intr(0, 20);
    tick(); tick();
    bus_if.evt_in[0] = 1'b1;
    repeat (SY) tick();
    bus_if.evt_in[0] = 1'b0;
    bus_if.ack[0]    = 1'b1;
    tick();
    bus_if.ack[0]    = 1'b0;
    check("sim_ack_low", 32'(bus_if.intr_out[0]), 32'd0);
    repeat (4) begin
      tick();
      check("sim_collect_hold", 32'(bus_if.intr_out[0]), 32'd0);
    end
    pulse(0);
    wait_intr(0, 20);
    check("sim_batch", 32'(bus_if.batch_cnt[0 +: CW]), 32'd2);
    ack_pulse(0);
    tick();

    // thresh 0 behaves as 1; other sources stay quiet
    bus_if.thresh = '0;
    pulse(0);
    wait_intr(0, 20);
    check("thr0_batch", 32'(bus_if.batch_cnt[0 +: CW]), 32'd1);
    check("thr0_others", 32'(bus_if.intr_out[NS-1:1]), 32'd0);
    ack_pulse(0);
    tick();

    // random traffic, including a mid-run reset
    for (int i = 0; i < NS; i++) hold[i] = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        bus_if.thresh  = CW'($urandom_range(0, 5));
        bus_if.timeout = ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(5, 40));
      end
      srst = (c >= 1500 && c < 1503);
      for (int i = 0; i < NS; i++) begin
        hold[i]++;
        if (hold[i] >= 2 && $urandom_range(0, 2) == 0) begin
          bus_if.evt_in[i] = ~bus_if.evt_in[i];
          hold[i] = 0;
        end
        bus_if.ack[i] = !bus_if.ack[i] && ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    srst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
